pulse_stretch_tx: RTL

- Output-side counterpart of the input dejitter filters: it guarantees stable output levels rather than requiring stable input levels.
- Converts single-cycle event requests from internal logic into clean output pulses. Each pulse has a guaranteed minimum asserted width and a guaranteed minimum de-asserted gap.
- Typical loads: LDAC/strobe pins, status LEDs, handshake lines to slow external devices.
- Requests that arrive during an active pulse or gap are queued in a saturating counter and replayed back-to-back.

---
 rtl/pulse_stretch_tx_if.sv | 29 ++
 rtl/pulse_stretch_tx.sv | 113 +++++++++++
 2 files changed

// File: rtl/pulse_stretch_tx_if.sv
// Request/response bundle for pulse_stretch_tx: request strobe in, conditioned pulse and
// queue status out. clk/rst stay outside the bundle.
interface pulse_stretch_tx_if #(
  parameter int unsigned C_PENDING_WIDTH = 4
) ();
  logic                       trigger_in;
  logic                       signal_out;
  logic                       busy;
  logic [C_PENDING_WIDTH-1:0] pending_cnt;
  logic                       overflow;

  // Requesting side
  modport master (
    output trigger_in,
    input  signal_out,
    input  busy,
    input  pending_cnt,
    input  overflow
  );

  // Pulse generator side
  modport slave (
    input  trigger_in,
    output signal_out,
    output busy,
    output pending_cnt,
    output overflow
  );
endinterface

// File: rtl/pulse_stretch_tx.sv
// Output pulse stretcher: turns single-cycle requests into pulses with a guaranteed minimum
// asserted width and de-asserted gap. Requests arriving mid-pulse/gap are queued in a
// saturating counter and replayed back-to-back.
module pulse_stretch_tx #(
  parameter int unsigned C_HIGH_CYCLES     = 16,
  parameter int unsigned C_LOW_CYCLES      = 16,
  parameter logic        C_OUTPUT_POLARITY = 1'b0,
  parameter int unsigned C_PENDING_WIDTH   = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  pulse_stretch_tx_if.slave  io_bus
);

  localparam int unsigned CntMax = (C_HIGH_CYCLES > C_LOW_CYCLES) ? C_HIGH_CYCLES : C_LOW_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0]            HiLoad  = CntW'(C_HIGH_CYCLES - 1);
  localparam logic [CntW-1:0]            LoLoad  = CntW'(C_LOW_CYCLES - 1);
  localparam logic [CntW-1:0]            CntOne  = CntW'(1);
  localparam logic [C_PENDING_WIDTH-1:0] PendOne = C_PENDING_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StAssert, StGap} state_e;

  state_e                     r_state;
  logic [CntW-1:0]            r_cnt;
  logic [C_PENDING_WIDTH-1:0] r_pend;
  logic                       r_sig;
  logic                       r_busy;
  logic                       r_ovf;

  logic w_cnt_zero;
  logic w_gap_exit;
  logic w_deq;
  logic w_enq;
  logic w_full;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_gap_exit = (r_state == StGap) && w_cnt_zero;
  // A queued request is replayed at gap exit in preference to a fresh trigger.
  assign w_deq      = w_gap_exit && (r_pend != '0);
  // A trigger at gap exit with an empty queue starts the next pulse directly instead.
  assign w_enq      = io_bus.trigger_in && (r_state != StIdle) && !(w_gap_exit && (r_pend == '0));
  assign w_full     = &r_pend;

  // Pulse FSM, phase counter, pending queue and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_sig   <= ~C_OUTPUT_POLARITY;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (w_enq && !w_deq) begin
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_pend <= r_pend + PendOne;
        end
      end else if (w_deq && !w_enq) begin
        r_pend <= r_pend - PendOne;
      end

      unique case (r_state)
        StIdle: begin
          if (io_bus.trigger_in) begin
            r_state <= StAssert;
            r_cnt   <= HiLoad;
            r_sig   <= C_OUTPUT_POLARITY;
            r_busy  <= 1'b1;
          end
        end
        StAssert: begin
          if (w_cnt_zero) begin
            r_state <= StGap;
            r_cnt   <= LoLoad;
            r_sig   <= ~C_OUTPUT_POLARITY;
          end else begin
            r_cnt <= r_cnt - CntOne;
          end
        end
        StGap: begin
          if (w_cnt_zero) begin
            if ((r_pend != '0) || io_bus.trigger_in) begin
              r_state <= StAssert;
              r_cnt   <= HiLoad;
              r_sig   <= C_OUTPUT_POLARITY;
            end else begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - CntOne;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_sig   <= ~C_OUTPUT_POLARITY;
        end
      endcase
    end
  end

  assign io_bus.signal_out  = r_sig;
  assign io_bus.busy        = r_busy;
  assign io_bus.pending_cnt = r_pend;
  assign io_bus.overflow    = r_ovf;

endmodule
